// File: rtl/m_cpu_pkg.sv
// Shared CPU definitions: FSM state codes, opcode5 constants, instruction
// type classes and the default halt register, used by the control FSM and
// by the datapath type decoder.
package m_cpu_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MA   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } m_state_e;

  typedef enum logic [2:0] {
    T_I  = 3'd0,
    T_R  = 3'd1,
    T_U  = 3'd2,
    T_J  = 3'd3,
    T_B  = 3'd4,
    T_S  = 3'd5,
    T_LD = 3'd6
  } m_type_e;

  localparam logic [4:0] OP_J     = 5'b11011;
  localparam logic [4:0] OP_B     = 5'b11000;
  localparam logic [4:0] OP_S     = 5'b01000;
  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_LD    = 5'b00000;

  // Writing this register halts the processor unless the top overrides it.
  localparam logic [4:0] C_HALT_RD = 5'd30;

  // Anything not recognised is treated as an I-type (register + immediate).
  function automatic m_type_e f_decode_type(input logic [4:0] opcode5);
    m_type_e t;
    case (opcode5)
      OP_J:             t = T_J;
      OP_B:             t = T_B;
      OP_S:             t = T_S;
      OP_R:             t = T_R;
      OP_LUI, OP_AUIPC: t = T_U;
      OP_LD:            t = T_LD;
      default:          t = T_I;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/m_get_type.sv
// Instruction type decoder: classifies opcode bits [6:2] into the coarse
// instruction classes the control FSM sequences on.
module m_get_type
  import m_cpu_pkg::*;
(
  input  logic [4:0] w_opcode5,
  output logic [2:0] w_type
);

  // Pure lookup so the datapath and the controller agree on the class.
  always_comb begin
    w_type = f_decode_type(w_opcode5);
  end

endmodule

// File: rtl/m_multicycle_ctrl.sv
// Multi-cycle RV32 controller: sequences IF/ID/EX/MA/WB per instruction,
// stalls in MA on data memory, counts retired instructions and stops in
// HALT after a write-back to the halt register.
module m_multicycle_ctrl
  import m_cpu_pkg::*;
#(
  parameter int         P_RET_W   = 32,
  parameter logic [4:0] P_HALT_RD = C_HALT_RD
) (
  input  logic               w_clk,
  input  logic               w_rst,
  input  logic [4:0]         w_opcode5,
  input  logic [4:0]         w_rd_idx,
  input  logic               w_is_pc_branched,
  input  logic               w_mem_ready,
  output logic               w_ir_we,
  output logic               w_pc_we,
  output logic               w_pc_sel,
  output logic               w_rf_we,
  output logic               w_dmem_re,
  output logic               w_dmem_we,
  output logic               w_wb_sel,
  output logic               w_halted,
  output logic [2:0]         w_state,
  output logic [P_RET_W-1:0] w_retired
);

  m_state_e           state;
  logic               load_flag;
  logic [P_RET_W-1:0] retired_cnt;
  logic [2:0]         inst_type;
  logic               retire;
  logic               is_b;
  logic               is_j;
  logic               is_ld;
  logic               is_st;

  m_get_type u_get_type (
    .w_opcode5 (w_opcode5),
    .w_type    (inst_type)
  );

  assign is_b  = (inst_type == T_B);
  assign is_j  = (inst_type == T_J);
  assign is_ld = (inst_type == T_LD);
  assign is_st = (inst_type == T_S);

  assign w_state   = state;
  assign w_retired = retired_cnt;

  // Output decode from the current state; reset masks every enable so nothing
  // is written while the core is being reset, even mid memory access.
  always_comb begin
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_pc_sel  = 1'b0;
    w_rf_we   = 1'b0;
    w_dmem_re = 1'b0;
    w_dmem_we = 1'b0;
    w_wb_sel  = 1'b0;
    retire    = 1'b0;
    if (!w_rst) begin
      case (state)
        S_IF: w_ir_we = 1'b1;
        S_EX: begin
          if (is_b) begin
            w_pc_we  = 1'b1;
            w_pc_sel = w_is_pc_branched;
            retire   = 1'b1;
          end
        end
        S_MA: begin
          w_dmem_re = is_ld;
          w_dmem_we = is_st;
          if (is_st && w_mem_ready) begin
            w_pc_we = 1'b1;
            retire  = 1'b1;
          end
        end
        S_WB: begin
          w_rf_we  = 1'b1;
          w_pc_we  = 1'b1;
          w_pc_sel = is_j;
          w_wb_sel = load_flag;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Halt is simply being parked in the HALT state, which only reset leaves.
  always_comb begin
    w_halted = (state == S_HALT);
  end

  // State sequencing, load flag for write-back muxing and retire counter.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state       <= S_IF;
      load_flag   <= 1'b0;
      retired_cnt <= '0;
    end else begin
      if (retire) begin
        retired_cnt <= retired_cnt + P_RET_W'(1);
      end
      case (state)
        S_IF: state <= S_ID;
        S_ID: state <= S_EX;
        S_EX: begin
          if (is_b) begin
            state <= S_IF;
          end else if (is_ld || is_st) begin
            state <= S_MA;
          end else begin
            state <= S_WB;
          end
        end
        S_MA: begin
          if (!(is_ld || is_st)) begin
            state <= S_IF;
          end else if (w_mem_ready) begin
            if (is_ld) begin
              load_flag <= 1'b1;
              state     <= S_WB;
            end else begin
              state <= S_IF;
            end
          end
        end
        S_WB: begin
          load_flag <= 1'b0;
          state     <= (w_rd_idx == P_HALT_RD) ? S_HALT : S_IF;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_m_multicycle_ctrl.sv
// Self-checking bench for the multi-cycle controller: a table of single
// instructions with hand-derived per-instruction behaviour, followed by
// hand-written halt, mid-access reset and counter wrap sequences.
module tb_m_multicycle_ctrl;
  import m_cpu_pkg::*;

  logic        w_clk;
  logic        w_rst;
  logic [4:0]  w_opcode5;
  logic [4:0]  w_rd_idx;
  logic        w_is_pc_branched;
  logic        w_mem_ready;
  logic        w_ir_we;
  logic        w_pc_we;
  logic        w_pc_sel;
  logic        w_rf_we;
  logic        w_dmem_re;
  logic        w_dmem_we;
  logic        w_wb_sel;
  logic        w_halted;
  logic [2:0]  w_state;
  logic [31:0] w_retired;

  int passCount;
  int checkCount;
  logic [31:0] expRetired;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic        br;
    int          nWait;
    int          cycles;
    int          irN;
    int          pcN;
    int          rfN;
    int          reN;
    int          weN;
    logic        pcSel;
    logic        wbSel;
    logic [23:0] trace;
  } vec_t;

  typedef struct {
    logic        done;
    int          cycles;
    int          irN;
    int          pcN;
    int          rfN;
    int          reN;
    int          weN;
    logic        pcSel;
    logic        wbSel;
    logic [2:0]  endState;
    logic [23:0] trace;
  } obs_t;

  vec_t vecs[13];

  m_multicycle_ctrl dut (
    .w_clk            (w_clk),
    .w_rst            (w_rst),
    .w_opcode5        (w_opcode5),
    .w_rd_idx         (w_rd_idx),
    .w_is_pc_branched (w_is_pc_branched),
    .w_mem_ready      (w_mem_ready),
    .w_ir_we          (w_ir_we),
    .w_pc_we          (w_pc_we),
    .w_pc_sel         (w_pc_sel),
    .w_rf_we          (w_rf_we),
    .w_dmem_re        (w_dmem_re),
    .w_dmem_we        (w_dmem_we),
    .w_wb_sel         (w_wb_sel),
    .w_halted         (w_halted),
    .w_state          (w_state),
    .w_retired        (w_retired)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  // Global safety net in case a sequence below stops making progress.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Holds reset over two edges, checks the reset view, releases just after an
  // edge so the next cycle is a clean IF cycle.
  task automatic applyReset();
    w_rst = 1'b1;
    w_mem_ready = 1'b0;
    @(posedge w_clk);
    @(negedge w_clk);
    #1;
    checkOutput("rst_state", w_state, S_IF);
    checkOutput("rst_retired", w_retired, 0);
    checkOutput("rst_halted", w_halted, 0);
    checkOutput("rst_enables", {w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_dmem_re, w_dmem_we, w_wb_sel}, 0);
    @(posedge w_clk);
    #1;
    w_rst = 1'b0;
    expRetired = 0;
  endtask

  // Runs one instruction from its IF cycle until the FSM is back in IF or HALT,
  // counting enable pulses and recording the state trace.
  task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rd, input logic br,
                               input int nWait, output obs_t obs);
    int waited;
    waited = 0;
    obs = '{default: 0};
    w_opcode5 = op;
    w_rd_idx = rd;
    w_is_pc_branched = br;
    for (int c = 0; c < 40; c++) begin
      @(negedge w_clk);
      w_mem_ready = (w_state == S_MA) && (waited >= nWait);
      #1;
      obs.trace = {obs.trace[20:0], w_state};
      if (w_ir_we) obs.irN++;
      if (w_pc_we) begin obs.pcN++; obs.pcSel = w_pc_sel; end
      if (w_rf_we) begin obs.rfN++; obs.wbSel = w_wb_sel; end
      if (w_dmem_re) obs.reN++;
      if (w_dmem_we) obs.weN++;
      if (w_state == S_MA && !w_mem_ready) waited++;
      @(posedge w_clk);
      #1;
      w_mem_ready = 1'b0;
      if (w_state == S_IF || w_state == S_HALT) begin
        obs.done = 1'b1;
        obs.cycles = c + 1;
        obs.endState = w_state;
        break;
      end
    end
    checkOutput("instr_timeout", obs.done, 1);
  endtask

  initial begin
    obs_t obs;
    int bad;
    logic [31:0] holdRet;

    passCount = 0;
    checkCount = 0;
    expRetired = 0;
    w_rst = 1'b1;
    w_opcode5 = 5'd0;
    w_rd_idx = 5'd0;
    w_is_pc_branched = 1'b0;
    w_mem_ready = 1'b0;

    //          op        rd     br  nW cyc ir pc rf re we pcS wbS trace
    vecs[0]  = '{5'b00100, 5'd1, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 24'o0124};
    vecs[1]  = '{OP_R,     5'd2, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 24'o0124};
    vecs[2]  = '{OP_LUI,   5'd3, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 24'o0124};
    vecs[3]  = '{OP_AUIPC, 5'd4, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 24'o0124};
    vecs[4]  = '{OP_J,     5'd1, 0, 0, 4, 1, 1, 1, 0, 0, 1, 0, 24'o0124};
    vecs[5]  = '{OP_B,     5'd0, 1, 0, 3, 1, 1, 0, 0, 0, 1, 0, 24'o012};
    vecs[6]  = '{OP_B,     5'd0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 24'o012};
    vecs[7]  = '{OP_LD,    5'd5, 0, 3, 8, 1, 1, 1, 4, 0, 0, 1, 24'o01233334};
    vecs[8]  = '{OP_LD,    5'd5, 0, 0, 5, 1, 1, 1, 1, 0, 0, 1, 24'o01234};
    vecs[9]  = '{OP_S,     5'd0, 0, 2, 6, 1, 1, 0, 0, 3, 0, 0, 24'o012333};
    vecs[10] = '{OP_S,     5'd0, 0, 0, 4, 1, 1, 0, 0, 1, 0, 0, 24'o0123};
    vecs[11] = '{5'b11001, 5'd6, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 24'o0124};
    vecs[12] = '{5'b11111, 5'd7, 1, 0, 4, 1, 1, 1, 0, 0, 0, 0, 24'o0124};

    applyReset();

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].br, vecs[i].nWait, obs);
      expRetired = expRetired + 1;
      checkOutput($sformatf("v%0d_cycles", i), obs.cycles, vecs[i].cycles);
      checkOutput($sformatf("v%0d_trace", i), obs.trace, vecs[i].trace);
      checkOutput($sformatf("v%0d_ir_we", i), obs.irN, vecs[i].irN);
      checkOutput($sformatf("v%0d_pc_we", i), obs.pcN, vecs[i].pcN);
      checkOutput($sformatf("v%0d_rf_we", i), obs.rfN, vecs[i].rfN);
      checkOutput($sformatf("v%0d_dmem_re", i), obs.reN, vecs[i].reN);
      checkOutput($sformatf("v%0d_dmem_we", i), obs.weN, vecs[i].weN);
      checkOutput($sformatf("v%0d_pc_sel", i), obs.pcSel, vecs[i].pcSel);
      checkOutput($sformatf("v%0d_wb_sel", i), obs.wbSel, vecs[i].wbSel);
      checkOutput($sformatf("v%0d_end", i), obs.endState, S_IF);
      checkOutput($sformatf("v%0d_retired", i), w_retired, expRetired);
    end

    // addi x30,x0,1: write-back still happens, then the core parks in HALT.
    applyStimulus(5'b00100, 5'd30, 0, 0, obs);
    expRetired = expRetired + 1;
    checkOutput("halt_cycles", obs.cycles, 4);
    checkOutput("halt_rf_we", obs.rfN, 1);
    checkOutput("halt_pc_we", obs.pcN, 1);
    checkOutput("halt_end", obs.endState, S_HALT);
    checkOutput("halt_retired", w_retired, expRetired);
    bad = 0;
    holdRet = w_retired;
    for (int c = 0; c < 20; c++) begin
      @(negedge w_clk);
      w_mem_ready = c[0];
      w_opcode5 = (c[1]) ? OP_S : OP_LD;
      w_rd_idx = 5'd30;
      #1;
      if (w_halted !== 1'b1 || w_state !== S_HALT) bad++;
      if ({w_ir_we, w_pc_we, w_rf_we, w_dmem_re, w_dmem_we} !== 5'd0) bad++;
      if (w_retired !== holdRet) bad++;
    end
    checkOutput("halt_hold_bad_cycles", bad, 0);
    checkOutput("halt_frozen_retired", w_retired, expRetired);

    // Reset out of HALT, retire one addi, then reset during a stalled store.
    applyReset();
    applyStimulus(5'b00100, 5'd1, 0, 0, obs);
    expRetired = expRetired + 1;
    checkOutput("pre_sw_retired", w_retired, 1);
    w_opcode5 = OP_S;
    w_mem_ready = 1'b0;
    repeat (4) @(negedge w_clk);
    #1;
    checkOutput("sw_ma1_state", w_state, S_MA);
    checkOutput("sw_ma1_dmem_we", w_dmem_we, 1);
    @(negedge w_clk);
    w_rst = 1'b1;
    #1;
    checkOutput("sw_rst_dmem_we", w_dmem_we, 0);
    checkOutput("sw_rst_pc_we", w_pc_we, 0);
    @(posedge w_clk);
    #1;
    checkOutput("sw_rst_state", w_state, S_IF);
    checkOutput("sw_rst_retired", w_retired, 0);
    @(negedge w_clk);
    #1;
    checkOutput("sw_rst_ir_we", w_ir_we, 0);
    @(posedge w_clk);
    #1;
    w_rst = 1'b0;
    expRetired = 0;

    // Counter wrap: preset to all-ones, one addi takes it to zero.
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #2;
    release dut.retired_cnt;
    #1;
    checkOutput("wrap_preset", w_retired, 32'hFFFF_FFFF);
    applyStimulus(5'b00100, 5'd1, 0, 0, obs);
    checkOutput("wrap_cycles", obs.cycles, 4);
    checkOutput("wrap_retired", w_retired, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
